// File: rtl/shake_length_tracker.sv
// Tracks the byte length of a SHAKE absorb stream: bytes left, word slot within the rate block,
// and per-word byte masks. Also reports whether a separate all-padding block is needed afterwards.
module shake_length_tracker #(
    parameter int LEN_W       = 32,
    parameter int WORD_W      = 64,
    parameter int RATE0_WORDS = 21,
    parameter int RATE1_WORDS = 17
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic [LEN_W-1:0]                len_i,
    input  logic                            mode,
    input  logic                            step,
    output logic [LEN_W-1:0]                remaining,
    output logic [4:0]                      word_idx,
    output logic [$clog2(WORD_W/8):0]       word_bytes,
    output logic [WORD_W/8-1:0]             byte_mask,
    output logic                            last_word,
    output logic                            last_block,
    output logic                            block_end,
    output logic                            busy,
    output logic                            done,
    output logic                            pad_extra
);
    localparam int WB = WORD_W / 8;
    localparam int BW = $clog2(WB) + 1;
    // Wide enough to hold (RATE - word_idx) * WB alongside any LEN_W length.
    localparam int CW = LEN_W + 7 + BW;
    localparam logic [LEN_W-1:0] WB_L = LEN_W'(WB);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] rem_nx;
    logic [4:0]       idx_nx;
    logic             mode_r, mode_nx;
    logic             pad_nx;
    logic [5:0]       rate;
    logic             at_end;
    logic             full;
    logic [CW-1:0]    cap;

    assign rate   = mode_r ? 6'(RATE1_WORDS) : 6'(RATE0_WORDS);
    assign at_end = ({1'b0, word_idx} == rate - 6'd1);
    assign full   = (remaining >= WB_L);
    assign cap    = CW'(rate - {1'b0, word_idx}) * CW'(WB);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            word_idx  <= '0;
            mode_r    <= 1'b0;
            pad_extra <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= rem_nx;
            word_idx  <= idx_nx;
            mode_r    <= mode_nx;
            pad_extra <= pad_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rem_nx   = remaining;
        idx_nx   = word_idx;
        mode_nx  = mode_r;
        pad_nx   = pad_extra;
        if (load) begin
            rem_nx   = len_i;
            idx_nx   = '0;
            mode_nx  = mode;
            pad_nx   = (len_i == '0);
            state_nx = (len_i != '0) ? ACTIVE : DONE;
        end else if (step && state == ACTIVE) begin
            rem_nx = full ? remaining - WB_L : '0;
            idx_nx = at_end ? 5'd0 : word_idx + 5'd1;
            if (rem_nx == '0) begin
                state_nx = DONE;
                // A full word that closes the block leaves no room for the pad bits.
                pad_nx   = full && at_end;
            end
        end
    end

    always_comb begin
        word_bytes = '0;
        byte_mask  = '0;
        last_word  = 1'b0;
        last_block = 1'b0;
        block_end  = 1'b0;
        if (state == ACTIVE) begin
            word_bytes = full ? BW'(WB) : BW'(remaining);
            for (int i = 0; i < WB; i++) begin
                byte_mask[i] = (BW'(i) < word_bytes);
            end
            last_word  = (remaining <= WB_L);
            last_block = (CW'(remaining) <= cap);
            block_end  = at_end;
        end
    end

    assign busy = (state == ACTIVE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shake_length_tracker.sv
// Bench for shake_length_tracker: directed vector table, hand sequences for block boundaries,
// then random stimulus against an arithmetic reference model.
module tb_shake_length_tracker;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [31:0] len_i = '0;
    logic        mode = 1'b0;
    logic        step = 1'b0;
    logic [31:0] remaining;
    logic [4:0]  word_idx;
    logic [3:0]  word_bytes;
    logic [7:0]  byte_mask;
    logic        last_word, last_block, block_end, busy, done, pad_extra;

    int total = 0;
    int bad   = 0;

    shake_length_tracker dut (
        .clk(clk), .rst(rst), .load(load), .len_i(len_i), .mode(mode), .step(step),
        .remaining(remaining), .word_idx(word_idx), .word_bytes(word_bytes),
        .byte_mask(byte_mask), .last_word(last_word), .last_block(last_block),
        .block_end(block_end), .busy(busy), .done(done), .pad_extra(pad_extra)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, ld;
        logic [31:0] len;
        logic        md, st;
        longint      rem;
        int          idx, bsy, dn, pad, wb, lw, lb, be;
    } vec_t;

    vec_t vt[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input longint rem, input int idx, input int bsy,
                             input int dn, input int pad, input int wb, input int lw,
                             input int lb, input int be);
        check({tag, ".remaining"},  longint'(remaining),  rem);
        check({tag, ".word_idx"},   longint'(word_idx),   idx);
        check({tag, ".busy"},       longint'(busy),       bsy);
        check({tag, ".done"},       longint'(done),       dn);
        check({tag, ".pad_extra"},  longint'(pad_extra),  pad);
        check({tag, ".word_bytes"}, longint'(word_bytes), wb);
        check({tag, ".byte_mask"},  longint'(byte_mask),  (64'd1 << wb) - 1);
        check({tag, ".last_word"},  longint'(last_word),  lw);
        check({tag, ".last_block"}, longint'(last_block), lb);
        check({tag, ".block_end"},  longint'(block_end),  be);
    endtask

    // Reference model state
    longint m_rem;
    int     m_idx, m_mode, m_st, m_pad;  // m_st: 0 idle, 1 active, 2 done

    task automatic model_edge(input bit r, input bit ld, input longint len, input bit md, input bit st);
        int rate;
        longint used;
        bit was_full, was_end;
        rate = m_mode ? 17 : 21;
        if (r) begin
            m_rem = 0; m_idx = 0; m_mode = 0; m_st = 0; m_pad = 0;
        end else if (ld) begin
            m_rem = len; m_idx = 0; m_mode = md;
            m_st  = (len == 0) ? 2 : 1;
            m_pad = (len == 0);
        end else if (st && m_st == 1) begin
            was_full = (m_rem >= 8);
            was_end  = (m_idx == rate - 1);
            used     = was_full ? 8 : m_rem;
            m_rem    = m_rem - used;
            m_idx    = (m_idx + 1) % rate;
            if (m_rem == 0) begin
                m_st  = 2;
                m_pad = was_full && was_end;
            end
        end
    endtask

    task automatic model_check(input string tag);
        int rate, act, wb;
        rate = m_mode ? 17 : 21;
        act  = (m_st == 1);
        wb   = act ? int'((m_rem < 8) ? m_rem : 8) : 0;
        check_all(tag, m_rem, m_idx, act, m_st == 2, m_pad, wb,
                  act && (m_rem <= 8),
                  act && (m_rem <= longint'(rate - m_idx) * 8),
                  act && (m_idx == rate - 1));
    endtask

    initial begin
        // r ld len md st | rem idx busy done pad wb lw lb be
        vt[0]  = '{1, 0, 32'd0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 32'd20, 0, 0, 20, 0, 1, 0, 0, 8, 0, 1, 0};
        vt[2]  = '{0, 0, 32'd0,  0, 1, 12, 1, 1, 0, 0, 8, 0, 1, 0};
        vt[3]  = '{0, 0, 32'd0,  0, 1,  4, 2, 1, 0, 0, 4, 1, 1, 0};
        vt[4]  = '{0, 0, 32'd0,  0, 1,  0, 3, 0, 1, 0, 0, 0, 0, 0};
        vt[5]  = '{0, 0, 32'd0,  0, 1,  0, 3, 0, 1, 0, 0, 0, 0, 0};
        vt[6]  = '{0, 1, 32'd0,  1, 0,  0, 0, 0, 1, 1, 0, 0, 0, 0};
        vt[7]  = '{0, 0, 32'd0,  0, 1,  0, 0, 0, 1, 1, 0, 0, 0, 0};
        vt[8]  = '{0, 1, 32'd48, 0, 0, 48, 0, 1, 0, 0, 8, 0, 1, 0};
        vt[9]  = '{0, 0, 32'd0,  0, 1, 40, 1, 1, 0, 0, 8, 0, 1, 0};
        vt[10] = '{0, 0, 32'd0,  0, 1, 32, 2, 1, 0, 0, 8, 0, 1, 0};
        vt[11] = '{0, 1, 32'd50, 0, 1, 50, 0, 1, 0, 0, 8, 0, 1, 0};
        vt[12] = '{0, 0, 32'd0,  0, 1, 42, 1, 1, 0, 0, 8, 0, 1, 0};
        vt[13] = '{1, 1, 32'd99, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[14] = '{0, 0, 32'd0,  0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 15; i++) begin
            rst = vt[i].r; load = vt[i].ld; len_i = vt[i].len; mode = vt[i].md; step = vt[i].st;
            tick();
            check_all($sformatf("vec%0d", i), vt[i].rem, vt[i].idx, vt[i].bsy, vt[i].dn,
                      vt[i].pad, vt[i].wb, vt[i].lw, vt[i].lb, vt[i].be);
        end
        rst = 1'b0; load = 1'b0; step = 1'b0;

        // Exactly one SHAKE128 block of data: padding needs its own block.
        load = 1'b1; len_i = 32'd168; mode = 1'b0;
        tick();
        load = 1'b0; step = 1'b1;
        for (int k = 0; k < 21; k++) begin
            check($sformatf("b168.idx%0d", k), longint'(word_idx), k);
            check($sformatf("b168.last_block%0d", k), longint'(last_block), 1);
            check($sformatf("b168.block_end%0d", k), longint'(block_end), (k == 20));
            tick();
        end
        step = 1'b0;
        check("b168.done", longint'(done), 1);
        check("b168.pad_extra", longint'(pad_extra), 1);
        check("b168.busy", longint'(busy), 0);

        // 200 bytes in SHAKE256: spills into a second block, ends mid-block.
        load = 1'b1; len_i = 32'd200; mode = 1'b1;
        tick();
        load = 1'b0; step = 1'b1;
        for (int k = 0; k < 17; k++) begin
            check($sformatf("b200.last_block%0d", k), longint'(last_block), 0);
            tick();
        end
        check("b200.remaining", longint'(remaining), 64);
        check("b200.word_idx", longint'(word_idx), 0);
        check("b200.last_block", longint'(last_block), 1);
        for (int k = 0; k < 8; k++) tick();
        step = 1'b0;
        check("b200.done", longint'(done), 1);
        check("b200.pad_extra", longint'(pad_extra), 0);

        // Maximum length must not wrap the block-capacity comparison.
        load = 1'b1; len_i = 32'hFFFF_FFFF; mode = 1'b1;
        tick();
        load = 1'b0; step = 1'b1;
        check("max.remaining", longint'(remaining), 64'hFFFF_FFFF);
        check("max.last_block", longint'(last_block), 0);
        check("max.word_bytes", longint'(word_bytes), 8);
        tick();
        step = 1'b0;
        check("max.remaining_after", longint'(remaining), 64'hFFFF_FFF7);
        check("max.word_idx", longint'(word_idx), 1);

        // Randomized run against the reference model.
        rst = 1'b1; load = 1'b0; step = 1'b0;
        model_edge(1, 0, 0, 0, 0);
        tick();
        for (int n = 0; n < 1500; n++) begin
            rst  = ($urandom_range(0, 63) == 0);
            load = ($urandom_range(0, 11) == 0);
            mode = 1'($urandom);
            step = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: len_i = $urandom_range(0, 16);
                1: len_i = $urandom_range(0, 400);
                2: len_i = 32'hFFFF_FFFF - $urandom_range(0, 20);
                default: len_i = $urandom;
            endcase
            model_edge(rst, load, longint'(len_i), mode, step);
            tick();
            model_check($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shake_length_tracker.md
SHAKE_LENGTH_TRACKER -- requirements
Module: shake_length_tracker

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- LEN_W, 32, byte-length counter width.
- WORD_W, 64, data word width in bits; multiple of 8; WB = WORD_W/8 bytes per word.
- RATE0_WORDS, 21, words per block in mode 0 (SHAKE128, 168 B); range 1..32.
- RATE1_WORDS, 17, words per block in mode 1 (SHAKE256, 136 B); range 1..32.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock; rising edge.
- rst, in, 1, reset; synchronous, active-high.
- load, in, 1, start a new length; samples len_i and mode.
- len_i, in, LEN_W, total length in bytes.
- mode, in, 1, rate select: 0 = RATE0_WORDS, 1 = RATE1_WORDS.
- step, in, 1, one word consumed this cycle.
- remaining, out, LEN_W, bytes not yet consumed.
- word_idx, out, 5, word position within the current block.
- word_bytes, out, $clog2(WB)+1, valid bytes in the current word.
- byte_mask, out, WB, byte-valid mask for the current word; bit i = byte i.
- last_word, out, 1, current word is the final data word.
- last_block, out, 1, all remaining bytes fit in the current block.
- block_end, out, 1, current word is the last word slot of the block.
- busy, out, 1, state is ACTIVE.
- done, out, 1, state is DONE.
- pad_extra, out, 1, a separate all-padding block is required.

Function
REQ-003 FSM states IDLE, ACTIVE and DONE SHALL be used; RATE = selected RATE*_WORDS.
REQ-004 load in any state SHALL set remaining to len_i, word_idx to 0, register mode, and clear pad_extra; the next state SHALL be ACTIVE if len_i != 0, else DONE with pad_extra = 1.
REQ-005 load SHALL take priority over step in the same cycle; step SHALL be ignored in IDLE and DONE.
REQ-006 step in ACTIVE SHALL update remaining to remaining - WB when remaining >= WB, else to 0; no underflow.
REQ-007 step in ACTIVE SHALL set word_idx to 0 when word_idx == RATE-1, else to word_idx + 1.
REQ-008 A step that brings remaining to 0 SHALL move the FSM to DONE on that edge.
REQ-009 On that same edge, pad_extra SHALL be set to 1 iff the consumed word was full (remaining >= WB) and word_idx == RATE-1; otherwise it SHALL be 0.
REQ-010 DONE SHALL hold, with pad_extra stable, until load or rst.
REQ-011 The following outputs SHALL be combinational from registered state and SHALL be 0 outside ACTIVE:
- word_bytes = min(remaining, WB).
- byte_mask = low word_bytes bits set.
- last_word = (remaining <= WB).
- last_block = (remaining <= (RATE - word_idx)*WB), computed without overflow at LEN_W.
- block_end = (word_idx == RATE-1).
REQ-012 busy SHALL be (state == ACTIVE) and done SHALL be (state == DONE).
REQ-013 remaining and word_idx SHALL be visible in all states.
REQ-014 The length arithmetic SHALL be correct for len_i = 2^LEN_W - 1; the mode register SHALL change only on load.

Reset
REQ-015 rst SHALL force IDLE, remaining = 0, word_idx = 0, registered mode = 0, and pad_extra = 0; all outputs read 0 on the cycle after rst.
REQ-016 rst SHALL dominate load and step, including mid-operation.

Verification (WORD_W = 64, WB = 8)
REQ-017 load len_i = 20, mode 0, then step each cycle:
- word_bytes = 8, 8, 4; byte_mask = 0xFF, 0xFF, 0x0F.
- last_word only on the 3rd word.
- done = 1 after the 3rd step; pad_extra = 0.
REQ-018 load len_i = 168, mode 0, then 21 steps:
- last_block = 1 throughout.
- block_end only at word_idx = 20.
- done = 1 and pad_extra = 1.
REQ-019 load len_i = 0: done = 1 and pad_extra = 1 next cycle; word_bytes = 0; busy never asserts.
REQ-020 load len_i = 200, mode 1:
- last_block = 0 for the first 17 steps.
- After 17 steps: remaining = 64, word_idx = 0, last_block = 1.
- 8 more steps: done = 1, pad_extra = 0.
REQ-021 load len_i = 50 and step in the same cycle while ACTIVE with remaining = 32: remaining = 50 and word_idx = 0 next cycle.
REQ-022 rst asserted mid-ACTIVE together with step: next cycle busy = 0, done = 0, remaining = 0, word_idx = 0.
